// File: rtl/dpram_be_if.sv
// dpram_be_if: user-side port bundle of the dual-port byte-enable RAM (both access ports, clear control, collision strobe)
interface dpram_be_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 10,
  parameter int NB    = 4
);
  logic             I_init;
  logic             O_busy;
  logic [ASIZE-1:0] I_addr0, I_addr1;
  logic [DSIZE-1:0] I_wdata0, I_wdata1;
  logic [NB-1:0]    I_be0, I_be1;
  logic             I_ce0, I_ce1;
  logic             I_wr0, I_wr1;
  logic [DSIZE-1:0] O_rdata0, O_rdata1;
  logic             O_rvld0, O_rvld1;
  logic             O_coll;
  modport master (
    output I_init, I_addr0, I_addr1, I_wdata0, I_wdata1, I_be0, I_be1, I_ce0, I_ce1, I_wr0, I_wr1,
    input  O_busy, O_rdata0, O_rdata1, O_rvld0, O_rvld1, O_coll
  );
  modport slave (
    input  I_init, I_addr0, I_addr1, I_wdata0, I_wdata1, I_be0, I_be1, I_ce0, I_ce1, I_wr0, I_wr1,
    output O_busy, O_rdata0, O_rdata1, O_rvld0, O_rvld1, O_coll
  );
endinterface

// File: rtl/dpram_be.sv
// dpram_be: single-clock true-dual-port RAM with byte enables, RD_LAT 1/2, READ_FIRST/WRITE_FIRST return, clear FSM; DPRAM_BE_COLL_DET_EN adds O_coll
module dpram_be #(
  parameter string MEM_STYLE = "block",
  parameter int    DSIZE     = 32,
  parameter int    ASIZE     = 10,
  parameter int    BSIZE     = 8,
  parameter int    RD_LAT    = 1,
  parameter string WR_MODE   = "READ_FIRST"
) (
  input logic       I_clk0,
  input logic       I_rst,
  dpram_be_if.slave bus
);
  localparam int NB = DSIZE / BSIZE;
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] LAST = (ASIZE+1)'(DEPTH - 1);
  localparam logic [ASIZE:0] ONE = (ASIZE+1)'(1);
  localparam bit WF = (WR_MODE == "WRITE_FIRST");
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [ASIZE:0] cnt_q, cnt_d;
  (* ram_style = MEM_STYLE *) logic [DSIZE-1:0] mem [DEPTH];
  logic acc0, acc1, we0, we1;
  logic [DSIZE-1:0] old0, old1, ret0, ret1;
  logic [DSIZE-1:0] rd0_q, rd1_q;
  logic v0_q, v1_q;
  // user accesses are only accepted while idle and out of reset
  assign acc0 = bus.I_ce0 & (state_q == IDLE) & ~I_rst;
  assign acc1 = bus.I_ce1 & (state_q == IDLE) & ~I_rst;
  assign we0 = acc0 & bus.I_wr0;
  assign we1 = acc1 & bus.I_wr1;
  assign old0 = mem[bus.I_addr0];
  assign old1 = mem[bus.I_addr1];
  assign bus.O_busy = (state_q == CLEAR);
  // write-return word: WRITE_FIRST merges this port's own enabled lanes over the old word
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign ret0[k*BSIZE +: BSIZE] = (WF && we0 && bus.I_be0[k]) ? bus.I_wdata0[k*BSIZE +: BSIZE] : old0[k*BSIZE +: BSIZE];
    assign ret1[k*BSIZE +: BSIZE] = (WF && we1 && bus.I_be1[k]) ? bus.I_wdata1[k*BSIZE +: BSIZE] : old1[k*BSIZE +: BSIZE];
  end
  // clear FSM state and address counter
  always_ff @(posedge I_clk0) begin
    if (I_rst) begin
      state_q <= CLEAR;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  // clear sweeps every address once, then returns to idle; init restarts it from zero
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + ONE;
      state_d = (cnt_q == LAST) ? IDLE : CLEAR;
    end else if (bus.I_init) begin
      state_d = CLEAR;
      cnt_d = '0;
    end
  end
  // memory array: clear writes zero; otherwise port 1 lanes first so port 0 wins overlapping lanes
  always_ff @(posedge I_clk0) begin
    if (state_q == CLEAR) mem[cnt_q[ASIZE-1:0]] <= '0;
    else for (int i = 0; i < NB; i++) begin
      if (we1 && bus.I_be1[i]) mem[bus.I_addr1][i*BSIZE +: BSIZE] <= bus.I_wdata1[i*BSIZE +: BSIZE];
      if (we0 && bus.I_be0[i]) mem[bus.I_addr0][i*BSIZE +: BSIZE] <= bus.I_wdata0[i*BSIZE +: BSIZE];
    end
  end
  // first read stage: data captured only on accepted accesses so it holds otherwise
  always_ff @(posedge I_clk0) begin
    if (I_rst) begin
      {v0_q, v1_q} <= '0;
      {rd0_q, rd1_q} <= '0;
    end else begin
      v0_q <= acc0;
      v1_q <= acc1;
      if (acc0) rd0_q <= ret0;
      if (acc1) rd1_q <= ret1;
    end
  end
  if (RD_LAT == 2) begin : g_lat2
    logic [DSIZE-1:0] rd0_p_q, rd1_p_q;
    logic v0_p_q, v1_p_q;
    // optional output register stage
    always_ff @(posedge I_clk0) begin
      if (I_rst) begin
        {v0_p_q, v1_p_q} <= '0;
        {rd0_p_q, rd1_p_q} <= '0;
      end else begin
        v0_p_q <= v0_q;
        v1_p_q <= v1_q;
        if (v0_q) rd0_p_q <= rd0_q;
        if (v1_q) rd1_p_q <= rd1_q;
      end
    end
    assign bus.O_rdata0 = rd0_p_q;
    assign bus.O_rdata1 = rd1_p_q;
    assign bus.O_rvld0 = v0_p_q;
    assign bus.O_rvld1 = v1_p_q;
  end else begin : g_lat1
    assign bus.O_rdata0 = rd0_q;
    assign bus.O_rdata1 = rd1_q;
    assign bus.O_rvld0 = v0_q;
    assign bus.O_rvld1 = v1_q;
  end
`ifdef DPRAM_BE_COLL_DET_EN
  logic coll_q;
  // registered strobe for same-address writes with at least one shared lane
  always_ff @(posedge I_clk0) begin
    if (I_rst) coll_q <= 1'b0;
    else coll_q <= we0 & we1 & (bus.I_addr0 == bus.I_addr1) & (|(bus.I_be0 & bus.I_be1));
  end
  assign bus.O_coll = coll_q;
`else
  assign bus.O_coll = 1'b0;
`endif
endmodule

// File: tb/tb_dpram_be.sv
// tb_dpram_be: directed vector table plus clear/reset sequences and random scoreboard traffic on RD_LAT=1 READ_FIRST and RD_LAT=2 WRITE_FIRST instances
module tb_dpram_be;
`ifdef DPRAM_BE_COLL_DET_EN
  localparam logic COLL = 1'b1;
`else
  localparam logic COLL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic init, ce0, ce1, wr0, wr1;
  logic [9:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0] be0, be1;
  dpram_be_if #(.DSIZE(32), .ASIZE(10), .NB(4)) b1 ();
  dpram_be_if #(.DSIZE(32), .ASIZE(10), .NB(4)) b2 ();
  assign b1.I_init = init;     assign b2.I_init = init;
  assign b1.I_ce0 = ce0;       assign b2.I_ce0 = ce0;
  assign b1.I_ce1 = ce1;       assign b2.I_ce1 = ce1;
  assign b1.I_wr0 = wr0;       assign b2.I_wr0 = wr0;
  assign b1.I_wr1 = wr1;       assign b2.I_wr1 = wr1;
  assign b1.I_addr0 = addr0;   assign b2.I_addr0 = addr0;
  assign b1.I_addr1 = addr1;   assign b2.I_addr1 = addr1;
  assign b1.I_wdata0 = wdata0; assign b2.I_wdata0 = wdata0;
  assign b1.I_wdata1 = wdata1; assign b2.I_wdata1 = wdata1;
  assign b1.I_be0 = be0;       assign b2.I_be0 = be0;
  assign b1.I_be1 = be1;       assign b2.I_be1 = be1;
  dpram_be #(.RD_LAT(1), .WR_MODE("READ_FIRST")) u1 (.I_clk0(clk), .I_rst(rst), .bus(b1));
  dpram_be #(.RD_LAT(2), .WR_MODE("WRITE_FIRST")) u2 (.I_clk0(clk), .I_rst(rst), .bus(b2));
  typedef struct {
    logic c0, w0; logic [9:0] a0; logic [31:0] d0; logic [3:0] b0;
    logic c1, w1; logic [9:0] a1; logic [31:0] d1; logic [3:0] b1;
    logic [31:0] rf0, rf1, wf0, wf1;
    logic v0, v1, cl;
  } vec_t;
  vec_t tv [14];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
    for (int k = 0; k < 4; k++) mrg[k*8 +: 8] = b[k] ? d[k*8 +: 8] : o[k*8 +: 8];
  endfunction
  task automatic run_vec(input vec_t v, input string nm);
    ce0 = v.c0; wr0 = v.w0; addr0 = v.a0; wdata0 = v.d0; be0 = v.b0;
    ce1 = v.c1; wr1 = v.w1; addr1 = v.a1; wdata1 = v.d1; be1 = v.b1;
    step;
    chk({nm, " u1 rdata0"}, b1.O_rdata0, v.rf0);
    chk({nm, " u1 rdata1"}, b1.O_rdata1, v.rf1);
    chk({nm, " u1 rvld0"}, 32'(b1.O_rvld0), 32'(v.v0));
    chk({nm, " u1 rvld1"}, 32'(b1.O_rvld1), 32'(v.v1));
    chk({nm, " u1 coll"}, 32'(b1.O_coll), 32'(v.cl & COLL));
    chk({nm, " u2 early rvld"}, 32'({b2.O_rvld1, b2.O_rvld0}), 32'(0));
    ce0 = 1'b0; ce1 = 1'b0;
    step;
    chk({nm, " u1 late rvld"}, 32'({b1.O_rvld1, b1.O_rvld0}), 32'(0));
    chk({nm, " u1 coll off"}, 32'(b1.O_coll), 32'(0));
    chk({nm, " u2 rdata0"}, b2.O_rdata0, v.wf0);
    chk({nm, " u2 rdata1"}, b2.O_rdata1, v.wf1);
    chk({nm, " u2 rvld0"}, 32'(b2.O_rvld0), 32'(v.v0));
    chk({nm, " u2 rvld1"}, 32'(b2.O_rvld1), 32'(v.v1));
  endtask
  task automatic count_busy(input string nm, input int hold_init);
    int n = 0;
    logic bad = 1'b0;
    ce0 = 1'b1; wr0 = 1'b0; addr0 = 10'h005;
    ce1 = 1'b1; wr1 = 1'b1; addr1 = 10'h005; wdata1 = 32'hFFFFFFFF; be1 = 4'hF;
    while (b1.O_busy && n < 2000) begin
      if (b1.O_rvld0 | b1.O_rvld1 | b2.O_rvld0 | b2.O_rvld1) bad = 1'b1;
      init = (n < hold_init);
      step;
      n++;
    end
    init = 1'b0; ce0 = 1'b0; ce1 = 1'b0;
    chk({nm, " busy cycles"}, n, 1024);
    chk({nm, " rvld while busy"}, 32'(bad), 32'(0));
    chk({nm, " u2 busy"}, 32'(b2.O_busy), 32'(0));
  endtask
  initial begin
    logic [31:0] m [1024];
    logic [31:0] e1d0, e1d1, e2d0, e2d1, pd0, pd1, nd0, nd1, o0, o1;
    logic pv0, pv1, ecoll;
    int acc, vc1, vc2;
    init = 0; ce0 = 0; ce1 = 0; wr0 = 0; wr1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; be0 = 0; be1 = 0;
    tv[0]  = '{1,0,10'h000,0,4'h0,            1,0,10'h3FF,0,4'h0,            32'h0,32'h0,32'h0,32'h0, 1,1,0};
    tv[1]  = '{1,1,10'h005,32'h11223344,4'hF, 0,0,10'h000,0,4'h0,            32'h0,32'h0,32'h11223344,32'h0, 1,0,0};
    tv[2]  = '{1,1,10'h005,32'hAABBCCDD,4'h5, 1,0,10'h005,0,4'h0,            32'h11223344,32'h11223344,32'h11BB33DD,32'h11223344, 1,1,0};
    tv[3]  = '{1,0,10'h010,0,4'h0,            1,0,10'h005,0,4'h0,            32'h0,32'h11BB33DD,32'h0,32'h11BB33DD, 1,1,0};
    tv[4]  = '{1,1,10'h010,32'hDEADBEEF,4'hF, 1,0,10'h010,0,4'h0,            32'h0,32'h0,32'hDEADBEEF,32'h0, 1,1,0};
    tv[5]  = '{1,1,10'h020,32'h000000FF,4'h1, 1,1,10'h020,32'hAA00EE00,4'hF, 32'h0,32'h0,32'h000000FF,32'hAA00EE00, 1,1,1};
    tv[6]  = '{1,0,10'h020,0,4'h0,            1,0,10'h010,0,4'h0,            32'hAA00EEFF,32'hDEADBEEF,32'hAA00EEFF,32'hDEADBEEF, 1,1,0};
    tv[7]  = '{1,1,10'h020,32'h12345678,4'h0, 0,0,10'h000,0,4'h0,            32'hAA00EEFF,32'hDEADBEEF,32'hAA00EEFF,32'hDEADBEEF, 1,0,0};
    tv[8]  = '{0,0,10'h000,0,4'h0,            1,0,10'h020,0,4'h0,            32'hAA00EEFF,32'hAA00EEFF,32'hAA00EEFF,32'hAA00EEFF, 0,1,0};
    tv[9]  = '{1,0,10'h3FF,0,4'h0,            1,1,10'h3FF,32'h00000055,4'h1, 32'h0,32'h0,32'h0,32'h00000055, 1,1,0};
    tv[10] = '{1,0,10'h3FF,0,4'h0,            1,0,10'h000,0,4'h0,            32'h55,32'h0,32'h55,32'h0, 1,1,0};
    tv[11] = '{1,1,10'h3FF,32'h0000AA00,4'h2, 1,1,10'h3FF,32'hFFFFFFFF,4'h8, 32'h55,32'h55,32'h0000AA55,32'hFF000055, 1,1,0};
    tv[12] = '{1,0,10'h3FF,0,4'h0,            0,0,10'h000,0,4'h0,            32'hFF00AA55,32'h55,32'hFF00AA55,32'hFF000055, 1,0,0};
    tv[13] = '{0,0,10'h000,0,4'h0,            0,0,10'h000,0,4'h0,            32'hFF00AA55,32'h55,32'hFF00AA55,32'hFF000055, 0,0,0};
    step;
    step;
    chk("reset busy", 32'(b1.O_busy), 32'(1));
    chk("reset rvld", 32'({b1.O_rvld0, b1.O_rvld1, b2.O_rvld0, b2.O_rvld1}), 32'(0));
    chk("reset u1 rdata0", b1.O_rdata0, 32'h0);
    chk("reset u2 rdata1", b2.O_rdata1, 32'h0);
    chk("reset coll", 32'(b1.O_coll), 32'(0));
    rst = 1'b0;
    count_busy("clear0", 0);
    for (int i = 0; i < 14; i++) run_vec(tv[i], $sformatf("vec%0d", i));
    init = 1'b1;
    step;
    count_busy("init", 10);
    chk("clear keeps u1 rdata0", b1.O_rdata0, 32'hFF00AA55);
    chk("clear keeps u1 rdata1", b1.O_rdata1, 32'h00000055);
    chk("clear keeps u2 rdata1", b2.O_rdata1, 32'hFF000055);
    run_vec('{1,0,10'h005,0,4'h0, 1,0,10'h3FF,0,4'h0, 32'h0,32'h0,32'h0,32'h0, 1,1,0}, "post-clear a");
    run_vec('{1,0,10'h010,0,4'h0, 1,0,10'h020,0,4'h0, 32'h0,32'h0,32'h0,32'h0, 1,1,0}, "post-clear b");
    run_vec('{1,1,10'h3FF,32'h12345678,4'hF, 1,0,10'h3FF,0,4'h0, 32'h0,32'h0,32'h12345678,32'h0, 1,1,0}, "wr 3ff");
    run_vec('{0,0,10'h000,0,4'h0, 1,0,10'h3FF,0,4'h0, 32'h0,32'h12345678,32'h12345678,32'h12345678, 0,1,0}, "rd 3ff");
    init = 1'b1;
    step;
    init = 1'b0;
    for (int i = 0; i < 500; i++) step;
    chk("mid-clear busy", 32'(b1.O_busy), 32'(1));
    chk("mid-clear rdata held", b1.O_rdata1, 32'h12345678);
    rst = 1'b1; ce0 = 1'b1; wr0 = 1'b0; addr0 = 10'h3FF;
    step;
    rst = 1'b0; ce0 = 1'b0;
    chk("rst busy", 32'(b1.O_busy), 32'(1));
    chk("rst rvld", 32'({b1.O_rvld0, b1.O_rvld1, b2.O_rvld0, b2.O_rvld1}), 32'(0));
    chk("rst u1 rdata1", b1.O_rdata1, 32'h0);
    chk("rst u2 rdata", b2.O_rdata0 | b2.O_rdata1, 32'h0);
    count_busy("rst restart", 0);
    run_vec('{1,0,10'h3FF,0,4'h0, 1,0,10'h000,0,4'h0, 32'h0,32'h0,32'h0,32'h0, 1,1,0}, "post-rst");
    for (int i = 0; i < 1024; i++) m[i] = 32'h0;
    e1d0 = 0; e1d1 = 0; e2d0 = 0; e2d1 = 0; pd0 = 0; pd1 = 0; pv0 = 0; pv1 = 0;
    acc = 0; vc1 = 0; vc2 = 0;
    for (int it = 0; it < 400; it++) begin
      ce0 = ($urandom_range(0, 3) != 0); wr0 = 1'($urandom_range(0, 1));
      addr0 = 10'($urandom_range(0, 7)); wdata0 = $urandom; be0 = 4'($urandom);
      ce1 = ($urandom_range(0, 3) != 0); wr1 = 1'($urandom_range(0, 1));
      addr1 = 10'($urandom_range(0, 7)); wdata1 = $urandom; be1 = 4'($urandom);
      o0 = m[addr0];
      o1 = m[addr1];
      if (ce0) e1d0 = o0;
      if (ce1) e1d1 = o1;
      nd0 = (ce0 && wr0) ? mrg(o0, wdata0, be0) : o0;
      nd1 = (ce1 && wr1) ? mrg(o1, wdata1, be1) : o1;
      ecoll = ce0 & wr0 & ce1 & wr1 & (addr0 == addr1) & (|(be0 & be1));
      if (ce1 && wr1) m[addr1] = mrg(m[addr1], wdata1, be1);
      if (ce0 && wr0) m[addr0] = mrg(m[addr0], wdata0, be0);
      if (pv0) e2d0 = pd0;
      if (pv1) e2d1 = pd1;
      acc += int'(ce0) + int'(ce1);
      step;
      vc1 += int'(b1.O_rvld0) + int'(b1.O_rvld1);
      vc2 += int'(b2.O_rvld0) + int'(b2.O_rvld1);
      chk($sformatf("rnd%0d u1 rvld", it), 32'({b1.O_rvld1, b1.O_rvld0}), 32'({ce1, ce0}));
      chk($sformatf("rnd%0d u1 rdata0", it), b1.O_rdata0, e1d0);
      chk($sformatf("rnd%0d u1 rdata1", it), b1.O_rdata1, e1d1);
      chk($sformatf("rnd%0d u1 coll", it), 32'(b1.O_coll), 32'(ecoll & COLL));
      chk($sformatf("rnd%0d u2 rvld", it), 32'({b2.O_rvld1, b2.O_rvld0}), 32'({pv1, pv0}));
      chk($sformatf("rnd%0d u2 rdata0", it), b2.O_rdata0, e2d0);
      chk($sformatf("rnd%0d u2 rdata1", it), b2.O_rdata1, e2d1);
      pv0 = ce0; pv1 = ce1; pd0 = nd0; pd1 = nd1;
    end
    ce0 = 1'b0; ce1 = 1'b0;
    if (pv0) e2d0 = pd0;
    if (pv1) e2d1 = pd1;
    step;
    vc2 += int'(b2.O_rvld0) + int'(b2.O_rvld1);
    chk("rnd drain u2 rvld", 32'({b2.O_rvld1, b2.O_rvld0}), 32'({pv1, pv0}));
    chk("rnd drain u2 rdata0", b2.O_rdata0, e2d0);
    chk("rnd drain u2 rdata1", b2.O_rdata1, e2d1);
    chk("rnd u1 rvld count", vc1, acc);
    chk("rnd u2 rvld count", vc2, acc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dpram_be.md
# dpram_be

Single-clock true-dual-port RAM with per-byte write enables, configurable read latency, selectable read-during-write mode, read-valid strobes, and a hardware memory-clear state machine. It is the parametrised successor to the plain dual-port buffer RAM. It serves as the ibuf/obuf storage primitive in the cnna datapath, where the AXI write-in path and the compute read-out path share one clock.

## Interface
Parameters:
- MEM_STYLE, "block": synthesis ram_style attribute ("block"/"distributed"/"ultra").
- DSIZE, 32: data width; must be a multiple of BSIZE.
- ASIZE, 10: address width; DEPTH = 1<<ASIZE.
- BSIZE, 8: byte-lane width; NB = DSIZE/BSIZE lanes.
- RD_LAT, 1: read latency in cycles, 1 or 2 (2 adds an output register stage).
- WR_MODE, "READ_FIRST": same-port read-during-write result, "READ_FIRST" or "WRITE_FIRST".

Ports:
- I_clk0  in  1  sole clock, both ports.
- I_rst  in  1  synchronous, active-high reset.
- I_init  in  1  request memory clear (level sampled in IDLE).
- O_busy  out  1  clear in progress; user accesses ignored.
- I_addr0 / I_addr1  in  ASIZE  port 0 / port 1 address.
- I_wdata0 / I_wdata1  in  DSIZE  write data.
- I_be0 / I_be1  in  NB  byte-lane write enables.
- I_ce0 / I_ce1  in  1  access enable.
- I_wr0 / I_wr1  in  1  write (1) / read (0) when ce=1.
- O_rdata0 / O_rdata1  out  DSIZE  read data.
- O_rvld0 / O_rvld1  out  1  read data valid strobe.
- O_coll  out  1  write-write address collision pulse (only with macro).

## Operation
- Access per port per cycle: ce=0 → idle; ce=1, wr=0 → read; ce=1, wr=1 → write lanes with be[i]=1 and also return read data per WR_MODE.
- READ_FIRST: the write access returns the pre-write word. WRITE_FIRST: it returns the post-write word (old lanes merged with the newly written lanes).
- Cross-port read of an address the other port writes in the same cycle always returns the old word, regardless of WR_MODE.
- Both ports write the same address in the same cycle: per lane, be0=1 → port 0 data wins; be0=0 and be1=1 → port 1 data; neither set → unchanged.
- be all-zero with wr=1: no memory change; still a read access (rvld pulses).
- O_rdata holds its last value when no read completes. It is not cleared by the memory clear.
- Clear FSM states: IDLE, CLEAR.
  - Reset → CLEAR with counter = 0.
  - CLEAR: writes zero to address counter, increments counter; after writing DEPTH-1 → IDLE.
  - IDLE with I_init=1 → CLEAR with counter = 0.
  - I_init is ignored while in CLEAR.
- O_busy = 1 exactly while in CLEAR. During CLEAR all user ce are ignored: no writes, rvld stays 0.

## Timing
- Reset values: O_rdata0/1 = 0, O_rvld0/1 = 0, O_coll = 0, O_busy = 1 on the first cycle after reset.
- Clear duration: DEPTH cycles. O_busy deasserts in the cycle after address DEPTH-1 is written. The first user access is accepted in that cycle.
- Read latency: data and rvld appear RD_LAT cycles after the ce edge, both for reads and for write-return data.
- Back-to-back reads every cycle are supported at full throughput on both ports.
- Write data is visible to a read from either port issued in the following cycle.
- Reset asserted mid-clear or mid-read: the pipeline is flushed (rvld = 0, rdata = 0) and the FSM restarts CLEAR from address 0.
- Counter width: ASIZE+1 bits, so no wrap ambiguity at DEPTH-1.

## Configuration
- DPRAM_BE_COLL_DET_EN defined: O_coll pulses high for one cycle, the cycle after both ports perform ce & wr to the same address with overlapping be lanes. O_coll is registered and independent of RD_LAT.
- Macro undefined: O_coll is tied to 0 and the collision comparator is not built. Lane-priority write behaviour is unchanged.

## Test plan
- Reset, then idle → O_busy = 1 for 1024 cycles (ASIZE = 10); then a read of any address on both ports → 0x00000000 with rvld after RD_LAT.
- Port 0 writes 0xAABBCCDD to 0x005 with be = 4'b0101 over prior 0x11223344 → port 1 read next cycle returns 0x11BB33DD.
- Same-port write 0xDEADBEEF to 0x010 (old 0x0) → READ_FIRST returns 0x00000000, WRITE_FIRST returns 0xDEADBEEF; both after RD_LAT = 1 and RD_LAT = 2.
- Both ports write 0x020 in one cycle: port 0 writes 0x000000FF with be0 = 0001, port 1 writes 0xAA00EE00 with be1 = 1111 → stored word is 0xAA00EEFF; with the macro, O_coll pulses one cycle.
- I_init pulse after data has been written → busy for DEPTH cycles, reads during busy give rvld = 0, afterwards all addresses read 0; reset at clear address 500 → clear restarts at 0 and lasts the full DEPTH cycles.
- Continuous random read/write traffic on both ports at RD_LAT = 2, checked against a scoreboard model → no data mismatch, and the rvld count equals the number of accepted accesses.
